// File: rtl/demux_tdm_2ch_pkg.sv
// Shared definitions for the two-channel TDM demultiplexer: state encoding and default sizes.
package demux_tdm_2ch_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        EXP_CH1 = 2'd1,
        EXP_CH0 = 2'd2
    } tdm_state_t;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-alignment FSM: tracks which channel the next sample belongs to and decodes load/error strobes.
module tdm_sync_fsm
    import demux_tdm_2ch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic       i_sync,
    output logic [1:0] o_state,
    output logic       o_ld_ch0,
    output logic       o_ld_ch1,
    output logic       o_err,
    output logic       o_ch0_valid,
    output logic       o_ch1_valid,
    output logic       o_pair_valid,
    output logic       o_sync_err
);

    tdm_state_t r_state;
    tdm_state_t w_next;
    logic       w_ld_ch0;
    logic       w_ld_ch1;
    logic       w_err;

    // i_valid is a one-way strobe with no back-pressure: every cycle with i_valid=1 carries a sample
    // that is consumed on that edge; cycles with i_valid=0 leave the state and all strobes idle.
    always_comb begin
        w_next   = r_state;
        w_ld_ch0 = 1'b0;
        w_ld_ch1 = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_valid && i_sync) begin
                    w_ld_ch0 = 1'b1;
                    w_next   = EXP_CH1;
                end
            end
            EXP_CH1: begin
                if (i_valid) begin
                    if (i_sync) begin
                        w_ld_ch0 = 1'b1;
                        w_err    = 1'b1;
                    end else begin
                        w_ld_ch1 = 1'b1;
                        w_next   = EXP_CH0;
                    end
                end
            end
            EXP_CH0: begin
                if (i_valid) begin
                    if (i_sync) begin
                        w_ld_ch0 = 1'b1;
                        w_next   = EXP_CH1;
                    end else begin
                        w_err  = 1'b1;
                        w_next = HUNT;
                    end
                end
            end
            default: w_next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            o_ch0_valid  <= 1'b0;
            o_ch1_valid  <= 1'b0;
            o_pair_valid <= 1'b0;
            o_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            o_ch0_valid  <= w_ld_ch0;
            o_ch1_valid  <= w_ld_ch1;
            o_pair_valid <= w_ld_ch1;
            o_sync_err   <= w_err;
        end
    end

    assign o_state  = r_state;
    assign o_ld_ch0 = w_ld_ch0;
    assign o_ld_ch1 = w_ld_ch1;
    assign o_err    = w_err;

endmodule

// File: rtl/demux_tdm_2ch.sv
// Two-channel TDM demultiplexer: splits a ch0/ch1 sample stream into registered per-channel outputs.
module demux_tdm_2ch
    import demux_tdm_2ch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0_data,
    output logic             ch0_valid,
    output logic [WIDTH-1:0] ch1_data,
    output logic             ch1_valid,
    output logic             pair_valid,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       err_cnt,
    output logic [1:0]       o_dbg_state
);

    logic             w_ld_ch0;
    logic             w_ld_ch1;
    logic             w_err;
    logic [WIDTH-1:0] r_ch0_data;
    logic [WIDTH-1:0] r_ch1_data;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [7:0]       r_err_cnt;

    tdm_sync_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (din_valid),
        .i_sync       (frame_sync),
        .o_state      (o_dbg_state),
        .o_ld_ch0     (w_ld_ch0),
        .o_ld_ch1     (w_ld_ch1),
        .o_err        (w_err),
        .o_ch0_valid  (ch0_valid),
        .o_ch1_valid  (ch1_valid),
        .o_pair_valid (pair_valid),
        .o_sync_err   (sync_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch0_data  <= '0;
            r_ch1_data  <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_ld_ch0) r_ch0_data <= din;
            if (w_ld_ch1) begin
                r_ch1_data  <= din;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            // Error count sticks at 255; sync_err keeps pulsing from the FSM regardless.
            if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ch0_data  = r_ch0_data;
    assign ch1_data  = r_ch1_data;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_demux_tdm_2ch.sv
// Self-checking bench for demux_tdm_2ch: directed framing cases, counter boundaries and random streams.
module tb_demux_tdm_2ch;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] ch0_data;
    logic             ch0_valid;
    logic [WIDTH-1:0] ch1_data;
    logic             ch1_valid;
    logic             pair_valid;
    logic             sync_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [7:0]       err_cnt;
    logic [1:0]       dbg_state;

    demux_tdm_2ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch0_data    (ch0_data),
        .ch0_valid   (ch0_valid),
        .ch1_data    (ch1_data),
        .ch1_valid   (ch1_valid),
        .pair_valid  (pair_valid),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: the receiver is either searching for a channel-0 sample, holding a
    // channel-0 sample awaiting its partner, or has just closed a pair.
    localparam int M_SEARCH = 0;
    localparam int M_HALF   = 1;
    localparam int M_PAIRED = 2;

    int   m_mode;
    int   m_ch0, m_ch1, m_frames, m_errs;
    bit   m_v0, m_v1, m_err;
    logic [2*WIDTH-1:0] exp_q[$];

    task automatic model_step(input bit r, input bit v, input bit s, input int d);
        m_v0 = 0; m_v1 = 0; m_err = 0;
        if (r) begin
            m_mode = M_SEARCH; m_ch0 = 0; m_ch1 = 0; m_frames = 0; m_errs = 0;
            exp_q.delete();
        end else if (v) begin
            if (s) begin
                if (m_mode == M_HALF) m_err = 1;
                m_ch0 = d; m_v0 = 1; m_mode = M_HALF;
            end else if (m_mode == M_HALF) begin
                m_ch1 = d; m_v1 = 1; m_mode = M_PAIRED;
                m_frames = (m_frames + 1) % (1 << CNT_W);
                exp_q.push_back({m_ch0[WIDTH-1:0], m_ch1[WIDTH-1:0]});
            end else if (m_mode == M_PAIRED) begin
                m_err = 1; m_mode = M_SEARCH;
            end
            if (m_err) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        end
    endtask

    // driver: apply one cycle on the falling edge, check one step after the rising edge
    task automatic drive(input bit r, input bit v, input bit s, input int d);
        logic [2*WIDTH-1:0] p;
        @(negedge clk);
        rst = r; din_valid = v; frame_sync = s; din = d[WIDTH-1:0];
        @(posedge clk);
        model_step(r, v, s, d);
        #1;
        check("ch0_data",   ch0_data,   m_ch0);
        check("ch1_data",   ch1_data,   m_ch1);
        check("ch0_valid",  ch0_valid,  m_v0);
        check("ch1_valid",  ch1_valid,  m_v1);
        check("pair_valid", pair_valid, m_v1);
        check("sync_err",   sync_err,   m_err);
        check("frame_cnt",  frame_cnt,  m_frames);
        check("err_cnt",    err_cnt,    m_errs);
        check("valid_excl", ch0_valid & ch1_valid, 0);
        check("state_legal", dbg_state == 2'd3, 0);
        if (pair_valid === 1'b1) begin
            check("pair_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                p = exp_q.pop_front();
                check("pair_data", {ch0_data, ch1_data}, p);
            end
        end
    endtask

    task automatic smp(input int d, input bit s);
        drive(0, 1, s, d);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 8'hEE);
    endtask

    initial begin
        int pairs_seen;
        rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
        m_mode = M_SEARCH; m_ch0 = 0; m_ch1 = 0; m_frames = 0; m_errs = 0;
        m_v0 = 0; m_v1 = 0; m_err = 0;

        do_reset();
        check("reset_all_zero", {ch0_data, ch1_data, frame_cnt, err_cnt, ch0_valid, ch1_valid,
                                 pair_valid, sync_err}, 0);

        // two clean frames back-to-back
        smp(8'h11, 1); smp(8'h22, 0); smp(8'h33, 1); smp(8'h44, 0);
        check("two_frames_cnt", frame_cnt, 2);
        check("two_frames_ch0", ch0_data, 8'h33);
        check("two_frames_err", err_cnt, 0);

        // leading unsynchronised samples are dropped silently
        do_reset();
        smp(8'hAA, 0); smp(8'hBB, 0);
        check("hunt_drop_ch0", ch0_data, 0);
        smp(8'h11, 1); smp(8'h22, 0);
        check("hunt_pair_cnt", frame_cnt, 1);

        // resync while expecting ch1
        do_reset();
        smp(8'h11, 1); smp(8'h55, 1);
        check("resync_err_pulse", sync_err, 1);
        smp(8'h22, 0);
        check("resync_pair", {ch0_data, ch1_data}, 16'h5522);
        check("resync_err_cnt", err_cnt, 1);

        // lost sync while expecting ch0, then recovery
        do_reset();
        smp(8'h11, 1); smp(8'h22, 0); smp(8'h99, 0);
        check("lost_err_pulse", sync_err, 1);
        check("lost_hold", {ch0_data, ch1_data}, 16'h1122);
        drive(0, 0, 0, 8'h77);
        smp(8'h33, 1); smp(8'h44, 0);
        check("lost_recover_pair", {ch0_data, ch1_data}, 16'h3344);

        // mid-frame reset abandons the half pair
        do_reset();
        smp(8'h11, 1);
        drive(1, 0, 0, 0);
        check("midrst_zero", {ch0_data, frame_cnt, ch0_valid}, 0);
        smp(8'h22, 0);
        check("midrst_no_pair", pair_valid, 0);

        // frame counter wrap and error counter saturation
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            smp(i, 1); smp(i + 8'h80, 0);
            if (($urandom_range(0, 3) == 0)) drive(0, 0, 0, 0);
        end
        check("frame_wrap", frame_cnt, 1);
        for (int i = 0; i < 300; i++) begin
            smp(8'h10, 1); smp(8'h20, 0); smp(8'h30, 0);
        end
        check("err_saturate", err_cnt, 255);
        smp(8'h10, 1); smp(8'h20, 0); smp(8'h30, 0);
        check("err_sat_pulse", sync_err, 1);
        check("err_sat_hold", err_cnt, 255);

        // random stream with occasional resets
        do_reset();
        pairs_seen = 0;
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1), $urandom_range(0, 255));
            if (pair_valid === 1'b1) pairs_seen++;
        end
        check("random_pairs_seen", pairs_seen > 0, 1);
        drive(0, 0, 0, 0);
        check("pairs_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
